// File: rtl/gca_pkg.sv
// Shared definitions for the Gray-conversion arbiter: default sizes, the
// output register state type and the binary-to-Gray helper.
package gca_pkg;

  localparam int W_DEF     = 4;
  localparam int NREQ_DEF  = 4;
  localparam int GRAY_MAXW = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } gca_state_t;

  // Width-agnostic: callers zero-extend into GRAY_MAXW and truncate the result,
  // so the top Gray bit is always bin[W-1] ^ 0.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gca_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr,
// wrapping modulo NREQ, found by masking a doubled request vector.
module gca_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] masked;

  always_comb begin
    dbl    = {req, req};
    masked = '0;
    idx    = '0;
    any    = 1'b0;
    grant  = '0;
    // Upper copy supplies the wrapped-around requests below ptr.
    for (int i = 0; i < 2*NREQ; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    for (int i = 0; i < 2*NREQ; i++) begin
      if (masked[i] && !any) begin
        any = 1'b1;
        idx = (i >= NREQ) ? IDW'(i - NREQ) : IDW'(i);
      end
    end
    if (any) grant = NREQ'(1) << idx;
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered binary-to-Gray stage between
// NREQ valid/ready requesters; each result is tagged with the winner's index.
module gray_conv_arbiter
  import gca_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_bin,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_gray,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready,
  output logic              busy
);

  gca_state_t      state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic            can_load;
  logic            xfer;
  logic [W-1:0]    sel_bin;
  logic [W-1:0]    gray_p0;

  gca_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign out_valid = (state == ST_FULL);
  assign can_load  = !out_valid || out_ready;
  assign xfer      = can_load && gnt_any;
  assign req_ready = can_load ? gnt : '0;
  assign busy      = out_valid || (|req_valid);

  // Stage p0: select the winner's operand and convert combinationally
  assign sel_bin = req_bin[int'(gnt_idx)*W +: W];
  assign gray_p0 = W'(bin2gray(GRAY_MAXW'(sel_bin)));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (xfer) state_nxt = ST_FULL;
      ST_FULL: begin
        if (xfer)           state_nxt = ST_FULL;
        else if (out_ready) state_nxt = ST_EMPTY;
      end
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Stage p0 -> output register: loaded only on a requester transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      rr_ptr   <= '0;
      out_gray <= '0;
      out_id   <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        out_gray <= gray_p0;
        out_id   <= gnt_idx;
        rr_ptr   <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the round-robin Gray-conversion arbiter.
module tb_gray_conv_arbiter;

  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_bin;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_gray;
  logic [IDW-1:0]    out_id;
  logic              out_ready;
  logic              busy;

  int vectors;
  int miscompares;

  // Reference model state
  bit          m_valid;
  logic [W-1:0] m_gray;
  int          m_id;
  int          m_ptr;

  gray_conv_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int k = 0; k < W-1; k++) g[k] = b[k+1] ^ b[k];
    return g;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_gray  = '0;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  // Called at posedge+1: drive, check handshake, clock, check the result register.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] b, input logic ordy);
    bit           can;
    int           g;
    logic [NREQ-1:0] exp_rdy;
    logic [W-1:0] opnd;
    req_valid = v;
    req_bin   = b;
    out_ready = ordy;
    #1;
    can = !m_valid || ordy;
    g   = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    end
    exp_rdy = (can && g >= 0) ? (NREQ'(1) << g) : '0;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("busy", 32'(busy), 32'(m_valid || (v != 0)));
    if (can && g >= 0) begin
      opnd    = b[g*W +: W];
      m_valid = 1;
      m_gray  = ref_gray(opnd);
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_gray", 32'(out_gray), 32'(m_gray));
    check_eq("out_id", 32'(out_id), 32'(m_id));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_bin   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_gray", 32'(out_gray), 0);
    check_eq("rst_out_id", 32'(out_id), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] prev_gray;
    logic [3:0]   rr_ids [5];
    logic [3:0]   rr_gray[4];
    vectors     = 0;
    miscompares = 0;
    rr_ids  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    rr_gray = '{4'b0000, 4'b0111, 4'b1111, 4'b1000};

    do_reset();

    // Single request from requester 0
    cycle(4'b0001, 16'h000B, 1'b1);
    check_eq("single_gray", 32'(out_gray), 32'(4'b1110));
    check_eq("single_id", 32'(out_id), 0);

    // All four requesting, bins 0,5,10,15
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 16'hFA50, 1'b1);
      check_eq("rr_id", 32'(out_id), 32'(rr_ids[k]));
      check_eq("rr_gray", 32'(out_gray), 32'(rr_gray[k % 4]));
      check_eq("rr_valid", 32'(out_valid), 1);
    end

    // Pointer hold across idle cycles
    cycle(4'b0010, 16'h0000, 1'b1);
    repeat (5) cycle(4'b0000, 16'h0000, 1'b1);
    cycle(4'b1011, 16'h0000, 1'b1);
    check_eq("ptr_hold_id", 32'(out_id), 3);

    // Back-pressure with requester 3 pending
    cycle(4'b0100, 16'h0200, 1'b1);
    check_eq("bp_load_gray", 32'(out_gray), 32'(4'b0011));
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1000, 16'h5200, 1'b0);
      check_eq("bp_hold_id", 32'(out_id), 2);
      check_eq("bp_hold_gray", 32'(out_gray), 32'(4'b0011));
    end
    cycle(4'b1000, 16'h5200, 1'b1);
    check_eq("bp_release_id", 32'(out_id), 3);

    // Exhaustive conversion from requester 2
    prev_gray = '0;
    for (int b = 0; b < 16; b++) begin
      cycle(4'b0100, 16'(b) << 8, 1'b1);
      if (b > 0) check_eq("gray_step", 32'($countones(prev_gray ^ out_gray)), 1);
      prev_gray = out_gray;
    end
    check_eq("gray_all_ones", 32'(out_gray), 32'(4'b1000));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle(NREQ'($urandom), (NREQ*W)'($urandom), ($urandom_range(0, 9) < 7));
    end

    // Asynchronous reset while FULL
    cycle(4'b0001, 16'h0007, 1'b1);
    check_eq("pre_rst_valid", 32'(out_valid), 1);
    req_valid = '0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 0);
    check_eq("async_rst_gray", 32'(out_gray), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(4'b1111, 16'h1234, 1'b1);
    check_eq("post_rst_id", 32'(out_id), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
